// File: rtl/run_sequencer_pkg.sv
// Shared definitions for the run sequencer and the 8-bit core it launches.
//   seq_state_t      : sequencer FSM states
//   PROG_START_ADDR  : starting PC of each program slot (shared with the core)
//   prog_start_addr(): index -> starting PC lookup helper
package run_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StRun,
    StReport
  } seq_state_t;

  localparam int unsigned ProgAddrBits = 12;

  localparam logic [ProgAddrBits-1:0] PROG_START_ADDR [4] = '{
    12'h000,
    12'h100,
    12'h200,
    12'h300
  };

  function automatic logic [ProgAddrBits-1:0] prog_start_addr(input logic [1:0] idx);
    return PROG_START_ADDR[idx];
  endfunction

endpackage

// File: rtl/run_sequencer_if.sv
// Host/core-facing signal bundle of the run sequencer.
//   master : host side (drives go/prog_sel/run_all/abort and the core's done)
//   slave  : sequencer side (drives start/start_addr and status outputs)
interface run_sequencer_if #(
  parameter int unsigned PC_BITS  = 12,
  parameter int unsigned CYC_BITS = 16
) ();

  logic                go;
  logic [1:0]          prog_sel;
  logic                run_all;
  logic                abort;
  logic                done;
  logic                start;
  logic [PC_BITS-1:0]  start_addr;
  logic                busy;
  logic [1:0]          prog_idx;
  logic                finished;
  logic                timed_out;
  logic [CYC_BITS-1:0] cycle_count;
  logic                bad_sel;

  modport master (
    output go, prog_sel, run_all, abort, done,
    input  start, start_addr, busy, prog_idx, finished, timed_out, cycle_count, bad_sel
  );

  modport slave (
    input  go, prog_sel, run_all, abort, done,
    output start, start_addr, busy, prog_idx, finished, timed_out, cycle_count, bad_sel
  );

endinterface

// File: rtl/run_sequencer_prog_lut.sv
// Combinational program-index -> starting PC lookup.
//   idx_i  : program index
//   addr_o : starting PC for that program, PC_BITS wide
module run_sequencer_prog_lut
  import run_sequencer_pkg::*;
#(
  parameter int unsigned PC_BITS = 12
) (
  input  logic [1:0]         idx_i,
  output logic [PC_BITS-1:0] addr_o
);

  always_comb begin
    addr_o = PC_BITS'(prog_start_addr(idx_i));
  end

endmodule

// File: rtl/run_sequencer.sv
// Launch controller for the 8-bit core: picks a program, pulses the core's start line with
// the program's starting PC, waits for done, counts RUN cycles and enforces a watchdog.
// Optionally runs prog_sel..NUM_PROGS-1 back to back.
//   clock : single clock, posedge
//   reset : asynchronous, active-low
//   bus   : slave modport; go/prog_sel/run_all/abort/done in,
//           start/start_addr/busy/prog_idx/finished/timed_out/cycle_count/bad_sel out
// All outputs are registered.
module run_sequencer
  import run_sequencer_pkg::*;
#(
  parameter int unsigned PC_BITS    = 12,
  parameter int unsigned NUM_PROGS  = 3,
  parameter int unsigned START_HOLD = 2,
  parameter int unsigned CYC_BITS   = 16,
  parameter int unsigned TIMEOUT    = 4000
) (
  input logic            clock,
  input logic            reset,
  run_sequencer_if.slave bus
);

  // Hold counter runs START_HOLD-1 down to 0 while start is high.
  localparam int unsigned         HoldBits   = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;
  localparam logic [HoldBits-1:0] HoldInit   = HoldBits'(START_HOLD - 1);
  localparam logic [1:0]          LastProg   = 2'(NUM_PROGS - 1);
  localparam logic [CYC_BITS-1:0] TimeoutCnt = CYC_BITS'(TIMEOUT);
  localparam logic [PC_BITS-1:0]  ResetAddr  = PC_BITS'(PROG_START_ADDR[0]);

  seq_state_t          state_q, state_d;
  logic [HoldBits-1:0] hold_q, hold_d;
  logic [1:0]          prog_idx_q, prog_idx_d;
  logic                run_all_q, run_all_d;
  logic                start_q, start_d;
  logic                busy_q, busy_d;
  logic                finished_q, finished_d;
  logic                timed_out_q, timed_out_d;
  logic                bad_sel_q, bad_sel_d;
  logic [CYC_BITS-1:0] cycle_count_q, cycle_count_d;
  logic [CYC_BITS-1:0] cycle_inc;
  logic [PC_BITS-1:0]  start_addr_q;
  logic [PC_BITS-1:0]  lut_addr;

  // Look up the address for the index being registered so start_addr is valid with start.
  run_sequencer_prog_lut #(
    .PC_BITS (PC_BITS)
  ) u_prog_lut (
    .idx_i  (prog_idx_d),
    .addr_o (lut_addr)
  );

  always_comb begin
    cycle_inc = (cycle_count_q == '1) ? cycle_count_q : cycle_count_q + CYC_BITS'(1);
  end

  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    prog_idx_d    = prog_idx_q;
    run_all_d     = run_all_q;
    start_d       = 1'b0;
    finished_d    = 1'b0;
    timed_out_d   = timed_out_q;
    bad_sel_d     = 1'b0;
    cycle_count_d = cycle_count_q;

    if (bus.abort) begin
      // Cancel from anywhere: counters and flags hold, no finished pulse.
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.go) begin
            if (bus.prog_sel > LastProg) begin
              bad_sel_d = 1'b1;
            end else begin
              prog_idx_d    = bus.prog_sel;
              run_all_d     = bus.run_all;
              cycle_count_d = '0;
              timed_out_d   = 1'b0;
              hold_d        = HoldInit;
              start_d       = 1'b1;
              state_d       = StLaunch;
            end
          end
        end
        StLaunch: begin
          if (hold_q == '0) begin
            state_d = StRun;
          end else begin
            hold_d  = hold_q - HoldBits'(1);
            start_d = 1'b1;
          end
        end
        StRun: begin
          cycle_count_d = cycle_inc;
          // done has priority over a watchdog expiry in the same cycle.
          if (bus.done) begin
            state_d     = StReport;
            finished_d  = 1'b1;
            timed_out_d = 1'b0;
          end else if (cycle_inc >= TimeoutCnt) begin
            state_d     = StReport;
            finished_d  = 1'b1;
            timed_out_d = 1'b1;
          end
        end
        StReport: begin
          if (run_all_q && (prog_idx_q < LastProg)) begin
            prog_idx_d    = prog_idx_q + 2'd1;
            cycle_count_d = '0;
            timed_out_d   = 1'b0;
            hold_d        = HoldInit;
            start_d       = 1'b1;
            state_d       = StLaunch;
          end else begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      hold_q        <= '0;
      prog_idx_q    <= '0;
      run_all_q     <= 1'b0;
      start_q       <= 1'b0;
      busy_q        <= 1'b0;
      finished_q    <= 1'b0;
      timed_out_q   <= 1'b0;
      bad_sel_q     <= 1'b0;
      cycle_count_q <= '0;
      start_addr_q  <= ResetAddr;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      prog_idx_q    <= prog_idx_d;
      run_all_q     <= run_all_d;
      start_q       <= start_d;
      busy_q        <= busy_d;
      finished_q    <= finished_d;
      timed_out_q   <= timed_out_d;
      bad_sel_q     <= bad_sel_d;
      cycle_count_q <= cycle_count_d;
      start_addr_q  <= lut_addr;
    end
  end

  assign bus.start       = start_q;
  assign bus.start_addr  = start_addr_q;
  assign bus.busy        = busy_q;
  assign bus.prog_idx    = prog_idx_q;
  assign bus.finished    = finished_q;
  assign bus.timed_out   = timed_out_q;
  assign bus.cycle_count = cycle_count_q;
  assign bus.bad_sel     = bad_sel_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Scoreboard bench for run_sequencer (START_HOLD=2, TIMEOUT=20, NUM_PROGS=3).
// Stimulus pushes expected launch/finish/bad_sel events; a forked monitor pops and compares
// whenever the DUT presents one.
module tb_run_sequencer;

  localparam int StartHold = 2;

  typedef enum int {EvLaunch, EvFin, EvBad} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       idx;
    int       addr;
    int       to;
    int       cnt;
  } ev_t;

  ev_t  sb[$];
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  run_sequencer_if #(.PC_BITS(12), .CYC_BITS(16)) bus ();

  run_sequencer #(
    .PC_BITS    (12),
    .NUM_PROGS  (3),
    .START_HOLD (2),
    .CYC_BITS   (16),
    .TIMEOUT    (20)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic push(input ev_kind_t k, input int idx, input int addr, input int to,
                      input int cnt);
    ev_t e;
    e.kind = k; e.idx = idx; e.addr = addr; e.to = to; e.cnt = cnt;
    sb.push_back(e);
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic observe(input ev_kind_t k, input int idx, input int addr, input int to,
                         input int cnt);
    ev_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL unexpected_%s: got idx=%0d addr=0x%0h to=%0d cnt=%0d expected no event",
               k.name(), idx, addr, to, cnt);
      return;
    end
    e = sb.pop_front();
    if (e.kind != k || e.idx != idx || e.addr != addr || e.to != to || e.cnt != cnt) begin
      failures++;
      $display("FAIL event: got %s idx=%0d addr=0x%0h to=%0d cnt=%0d expected %s idx=%0d addr=0x%0h to=%0d cnt=%0d",
               k.name(), idx, addr, to, cnt, e.kind.name(), e.idx, e.addr, e.to, e.cnt);
    end
  endtask

  task automatic monitor();
    logic start_prev = 1'b0;
    int   len = 0;
    int   addr_at_rise = 0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        start_prev = 1'b0;
        len = 0;
      end else begin
        if (bus.start) begin
          if (!start_prev) begin
            len = 1;
            addr_at_rise = int'(bus.start_addr);
            observe(EvLaunch, int'(bus.prog_idx), int'(bus.start_addr), 0, 0);
          end else begin
            len++;
            check("start_addr_stable", int'(bus.start_addr), addr_at_rise);
          end
        end else if (start_prev) begin
          check("start_width", len, StartHold);
        end
        if (bus.finished) begin
          observe(EvFin, int'(bus.prog_idx), 0, int'(bus.timed_out), int'(bus.cycle_count));
        end
        if (bus.bad_sel) observe(EvBad, 0, 0, 0, 0);
        start_prev = bus.start;
      end
    end
  endtask

  task automatic issue_go(input int sel, input bit all);
    @(negedge clock);
    bus.go = 1'b1;
    bus.prog_sel = sel[1:0];
    bus.run_all = all;
    @(negedge clock);
    bus.go = 1'b0;
    bus.prog_sel = 2'd0;
    bus.run_all = 1'b0;
  endtask

  // Returns at the first negedge of RUN (start seen high, then low).
  task automatic wait_run();
    int n = 0;
    while (!bus.start && n < 50) begin @(negedge clock); n++; end
    while (bus.start && n < 50) begin @(negedge clock); n++; end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL wait_run: got no start pulse within 50 cycles expected one");
    end
  endtask

  // Assert done during RUN cycle k (called from RUN cycle 1).
  task automatic pulse_done(input int k);
    repeat (k - 1) @(negedge clock);
    bus.done = 1'b1;
    @(negedge clock);
    bus.done = 1'b0;
  endtask

  task automatic wait_fin();
    int n = 0;
    do begin @(negedge clock); n++; end while (!bus.finished && n < 60);
    if (!bus.finished) begin
      checks++;
      failures++;
      $display("FAIL wait_fin: got no finished within 60 cycles expected one");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected end of test");
    $fatal(1, "bench timeout");
  end

  initial begin
    bus.go = 1'b0; bus.prog_sel = 2'd0; bus.run_all = 1'b0; bus.abort = 1'b0; bus.done = 1'b0;
    fork
      monitor();
    join_none

    // Reset values.
    #1 reset = 1'b0;
    #2;
    check("rst_start", int'(bus.start), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_flags", int'({bus.finished, bus.timed_out, bus.bad_sel}), 0);
    check("rst_count", int'(bus.cycle_count), 0);
    check("rst_idx", int'(bus.prog_idx), 0);
    check("rst_addr", int'(bus.start_addr), 'h000);
    @(negedge clock);
    reset = 1'b1;

    // 1: single program 1, done at RUN cycle 7.
    push(EvLaunch, 1, 'h100, 0, 0);
    push(EvFin, 1, 0, 0, 7);
    issue_go(1, 1'b0);
    wait_run();
    pulse_done(7);
    @(negedge clock);
    check("t1_busy_idle", int'(bus.busy), 0);

    // 2: run_all from 0, counts 5/9/3.
    push(EvLaunch, 0, 'h000, 0, 0); push(EvFin, 0, 0, 0, 5);
    push(EvLaunch, 1, 'h100, 0, 0); push(EvFin, 1, 0, 0, 9);
    push(EvLaunch, 2, 'h200, 0, 0); push(EvFin, 2, 0, 0, 3);
    issue_go(0, 1'b1);
    wait_run(); pulse_done(5);
    wait_run(); pulse_done(9);
    wait_run(); pulse_done(3);
    @(negedge clock);
    check("t2_busy_idle", int'(bus.busy), 0);

    // 3: watchdog, then done on the 20th cycle.
    push(EvLaunch, 2, 'h200, 0, 0);
    push(EvFin, 2, 0, 1, 20);
    issue_go(2, 1'b0);
    wait_run();
    wait_fin();
    @(negedge clock);
    check("t3_timed_out_hold", int'(bus.timed_out), 1);
    check("t3_count_frozen", int'(bus.cycle_count), 20);
    check("t3_busy_idle", int'(bus.busy), 0);
    push(EvLaunch, 2, 'h200, 0, 0);
    push(EvFin, 2, 0, 0, 20);
    issue_go(2, 1'b0);
    wait_run();
    pulse_done(20);
    @(negedge clock);
    check("t3_done_wins", int'(bus.timed_out), 0);

    // 4: bad selection, then go in RUN and done in LAUNCH are ignored.
    push(EvBad, 0, 0, 0, 0);
    issue_go(3, 1'b0);
    check("t4_bad_busy", int'(bus.busy), 0);
    @(negedge clock);
    check("t4_bad_still_idle", int'(bus.busy), 0);
    push(EvLaunch, 1, 'h100, 0, 0);
    push(EvFin, 1, 0, 0, 4);
    issue_go(1, 1'b0);
    bus.done = 1'b1;
    @(negedge clock);
    bus.done = 1'b0;
    wait_run();
    @(negedge clock);
    bus.go = 1'b1;
    @(negedge clock);
    bus.go = 1'b0;
    @(negedge clock);
    bus.done = 1'b1;
    @(negedge clock);
    bus.done = 1'b0;
    repeat (3) @(negedge clock);
    check("t4_go_ignored", int'(bus.busy), 0);

    // 5: abort at RUN cycle 4.
    push(EvLaunch, 0, 'h000, 0, 0);
    issue_go(0, 1'b0);
    wait_run();
    repeat (3) @(negedge clock);
    bus.abort = 1'b1;
    @(negedge clock);
    bus.abort = 1'b0;
    check("t5_abort_busy", int'(bus.busy), 0);
    check("t5_abort_start", int'(bus.start), 0);
    check("t5_abort_count", int'(bus.cycle_count), 3);
    repeat (4) @(negedge clock);
    check("t5_stays_idle", int'(bus.busy), 0);

    // 6: asynchronous reset in LAUNCH.
    push(EvLaunch, 1, 'h100, 0, 0);
    issue_go(1, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_start", int'(bus.start), 0);
    check("t6_rst_busy", int'(bus.busy), 0);
    check("t6_rst_idx", int'(bus.prog_idx), 0);
    check("t6_rst_addr", int'(bus.start_addr), 'h000);
    check("t6_rst_flags", int'({bus.finished, bus.timed_out, bus.bad_sel}), 0);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("t6_idle_after", int'(bus.busy), 0);

    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
